// File: rtl/blitter.sv
// Sprite/clear blitter for a 128x64 1bpp framebuffer with XOR drawing and collision detect.
// Define BLIT_WRAP_EN to wrap off-plane bytes/rows instead of clipping them.
module blitter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  blit_op,
    input  logic [11:0] blit_src,
    input  logic [3:0]  blit_srcHeight,
    input  logic [6:0]  blit_destX,
    input  logic [5:0]  blit_destY,
    input  logic        blit_enable,
    output logic        blit_done,
    output logic        blit_collision,
    output logic        mem_en,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_out,
    output logic        fb_en,
    output logic        fb_wr,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_in,
    input  logic [7:0]  fb_out,
    output logic [3:0]  dbg_state
);

`ifdef BLIT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_FETCH_WAIT, S_FB_RD,
        S_FB_WAIT, S_FB_WR, S_NEXT_ROW, S_FINISH
    } state_t;

    state_t      state;
    logic        sp16_q;
    logic [6:0]  x_q;
    logic [5:0]  y_q;
    logic [3:0]  h_q;
    logic [3:0]  row;
    logic        fidx;
    logic [1:0]  b;
    logic [15:0] src_pat;
    logic        rd_v1, rd_v2;
    logic        en_prev;

    logic [5:0]  row_y;
    logic [3:0]  col_b, col_next;
    logic [23:0] span;
    logic [7:0]  cur_pat;
    logic        byte_last, row_last, more_rows, start;

    // Row pattern shifted right by the sub-byte offset; zero-filled on both sides.
    assign span = (sp16_q ? {src_pat, 8'h00} : {src_pat[7:0], 16'h0000}) >> x_q[2:0];

    always_comb begin
        cur_pat = span[7:0];
        case (b)
            2'd0:    cur_pat = span[23:16];
            2'd1:    cur_pat = span[15:8];
            default: cur_pat = span[7:0];
        endcase
    end

    assign row_y     = y_q + {2'b00, row};
    assign col_b     = x_q[6:3] + {2'b00, b};
    assign col_next  = col_b + 4'd1;
    assign byte_last = (b == (sp16_q ? 2'd2 : 2'd1)) || (!WRAP && col_b == 4'hF);
    assign row_last  = (row == (sp16_q ? 4'hF : h_q - 4'd1));
    assign more_rows = !row_last && (WRAP || row_y != 6'd63);
    assign start     = (state == S_IDLE) && blit_enable && !en_prev;
    assign fb_in     = (state == S_FB_WR) ? (fb_out ^ cur_pat) : 8'h00;
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            blit_done      <= 1'b1;
            blit_collision <= 1'b0;
            mem_en         <= 1'b0;
            mem_addr       <= 12'h000;
            fb_en          <= 1'b0;
            fb_wr          <= 1'b0;
            fb_addr        <= 10'h000;
            sp16_q         <= 1'b0;
            x_q            <= 7'h00;
            y_q            <= 6'h00;
            h_q            <= 4'h0;
            row            <= 4'h0;
            fidx           <= 1'b0;
            b              <= 2'd0;
            src_pat        <= 16'h0000;
            rd_v1          <= 1'b0;
            rd_v2          <= 1'b0;
            // Treat enable as already high so a held request needs a fresh edge.
            en_prev        <= 1'b1;
        end else begin
            en_prev <= blit_enable;
            rd_v1   <= (state == S_FETCH);
            rd_v2   <= rd_v1;
            if (rd_v2) src_pat <= {src_pat[7:0], mem_out};
            case (state)
                S_IDLE: if (start) begin
                    sp16_q         <= (blit_op == 3'd2);
                    x_q            <= blit_destX;
                    y_q            <= blit_destY;
                    h_q            <= blit_srcHeight;
                    row            <= 4'h0;
                    fidx           <= 1'b0;
                    b              <= 2'd0;
                    blit_collision <= 1'b0;
                    blit_done      <= 1'b0;
                    case (blit_op)
                        3'd0: begin
                            fb_addr <= 10'h000;
                            fb_en   <= 1'b1;
                            fb_wr   <= 1'b1;
                            state   <= S_CLEAR;
                        end
                        3'd1, 3'd2: begin
                            if (blit_op == 3'd1 && blit_srcHeight == 4'h0) begin
                                state <= S_FINISH;
                            end else begin
                                mem_addr <= blit_src;
                                mem_en   <= 1'b1;
                                state    <= S_FETCH;
                            end
                        end
                        default: state <= S_FINISH;
                    endcase
                end
                S_CLEAR: begin
                    if (fb_addr == 10'h3FF) begin
                        fb_en <= 1'b0;
                        fb_wr <= 1'b0;
                        state <= S_FINISH;
                    end else begin
                        fb_addr <= fb_addr + 10'd1;
                    end
                end
                S_FETCH: state <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
                    if (sp16_q && !fidx) begin
                        fidx     <= 1'b1;
                        mem_addr <= mem_addr + 12'd1;
                        state    <= S_FETCH;
                    end else begin
                        mem_en  <= 1'b0;
                        b       <= 2'd0;
                        fb_en   <= 1'b1;
                        fb_addr <= {row_y, x_q[6:3]};
                        state   <= S_FB_RD;
                    end
                end
                S_FB_RD: state <= S_FB_WAIT;
                S_FB_WAIT: begin
                    fb_wr <= 1'b1;
                    state <= S_FB_WR;
                end
                S_FB_WR: begin
                    fb_wr <= 1'b0;
                    if (|(fb_out & cur_pat)) blit_collision <= 1'b1;
                    if (!byte_last) begin
                        b       <= b + 2'd1;
                        fb_addr <= {row_y, col_next};
                        state   <= S_FB_RD;
                    end else begin
                        fb_en <= 1'b0;
                        // Source bytes of consecutive rows are contiguous in both sprite modes.
                        if (more_rows) begin
                            row      <= row + 4'd1;
                            fidx     <= 1'b0;
                            mem_addr <= mem_addr + 12'd1;
                            mem_en   <= 1'b1;
                            state    <= S_FETCH;
                        end else begin
                            state <= S_NEXT_ROW;
                        end
                    end
                end
                S_NEXT_ROW: state <= S_FINISH;
                S_FINISH: begin
                    mem_en    <= 1'b0;
                    fb_en     <= 1'b0;
                    fb_wr     <= 1'b0;
                    blit_done <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blitter.sv
// Self-checking bench for blitter: pixel-level reference model, memory/framebuffer models.
module tb_blitter;

`ifdef BLIT_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic        clk;
    logic        rst_n = 1'b1;
    logic [2:0]  blit_op = 3'd0;
    logic [11:0] blit_src = 12'h000;
    logic [3:0]  blit_srcHeight = 4'h0;
    logic [6:0]  blit_destX = 7'h00;
    logic [5:0]  blit_destY = 6'h00;
    logic        blit_enable = 1'b0;
    logic        blit_done, blit_collision, mem_en, fb_en, fb_wr;
    logic [11:0] mem_addr;
    logic [7:0]  mem_out = 8'h00, fb_out = 8'h00, fb_in;
    logic [9:0]  fb_addr;
    logic [3:0]  dbg_state;

    blitter dut (
        .clk(clk), .rst_n(rst_n), .blit_op(blit_op), .blit_src(blit_src),
        .blit_srcHeight(blit_srcHeight), .blit_destX(blit_destX), .blit_destY(blit_destY),
        .blit_enable(blit_enable), .blit_done(blit_done), .blit_collision(blit_collision),
        .mem_en(mem_en), .mem_addr(mem_addr), .mem_out(mem_out),
        .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_in(fb_in), .fb_out(fb_out),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  ram [4096];
    logic [7:0]  fb [1024];
    logic [7:0]  exp_fb [1024];
    logic [7:0]  m1 = 8'h00, f1 = 8'h00;
    logic [15:0] exp_q [$];
    int          fetch_t [$];
    int          cyc = 0, wr_count = 0, mem_cnt = 0, seq_err = 0, clear_base = 0;
    int          checks = 0, failures = 0;
    logic        mem_prev = 1'b0, in_clear = 1'b0, fill_req = 1'b0;
    logic [7:0]  fill_val = 8'h00;

    // Environment: 2-cycle program RAM and framebuffer, plus write/fetch monitors.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        m1       <= ram[mem_addr];
        mem_out  <= m1;
        f1       <= fb[fb_addr];
        fb_out   <= f1;
        mem_prev <= mem_en;
        if (mem_en) mem_cnt <= mem_cnt + 1;
        if (mem_en && !mem_prev) fetch_t.push_back(cyc);
        if (fill_req) begin
            for (int i = 0; i < 1024; i++) fb[i] <= fill_val;
        end else if (fb_en && fb_wr) begin
            fb[fb_addr] <= fb_in;
            wr_count    <= wr_count + 1;
            if (in_clear && (fb_addr != 10'(wr_count - clear_base) || fb_in != 8'h00))
                seq_err <= seq_err + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int fb_diff();
        int n = 0;
        for (int i = 0; i < 1024; i++) if (fb[i] !== exp_fb[i]) n++;
        return n;
    endfunction

    task automatic fill_fb(input logic [7:0] v);
        @(negedge clk);
        fill_val = v;
        fill_req = 1'b1;
        @(negedge clk);
        fill_req = 1'b0;
        for (int i = 0; i < 1024; i++) exp_fb[i] = v;
    endtask

    // Pixel-level reference: toggle every set sprite pixel, note hits on already-lit pixels.
    task automatic model_sprite(input int op, input int src, input int h, input int x,
                                input int y, output bit coll, output int writes);
        int yy, xx, idx, bp, w, nrows, nb, vis, rows_vis;
        logic [15:0] pat;
        coll = 1'b0;
        w = (op == 2) ? 16 : 8;
        nrows = (op == 2) ? 16 : h;
        nb = (op == 2) ? 3 : 2;
        vis = (WRAP || (16 - x / 8) >= nb) ? nb : 16 - x / 8;
        rows_vis = 0;
        for (int r = 0; r < nrows; r++) begin
            yy = y + r;
            if (yy > 63) begin
                if (!WRAP) continue;
                yy -= 64;
            end
            rows_vis++;
            if (w == 8) pat = {ram[(src + r) % 4096], 8'h00};
            else        pat = {ram[(src + 2 * r) % 4096], ram[(src + 2 * r + 1) % 4096]};
            for (int p = 0; p < w; p++) begin
                if (!pat[15 - p]) continue;
                xx = x + p;
                if (xx > 127) begin
                    if (!WRAP) continue;
                    xx -= 128;
                end
                idx = yy * 16 + xx / 8;
                bp = 7 - xx % 8;
                if (exp_fb[idx][bp]) coll = 1'b1;
                exp_fb[idx][bp] = ~exp_fb[idx][bp];
            end
        end
        writes = rows_vis * vis;
        for (int i = 1; i < rows_vis; i++) exp_q.push_back(16'(2 * (w / 8) + 3 * vis));
    endtask

    task automatic run_op(input string tag, input int op, input int src, input int h,
                          input int x, input int y, input bit toggle, input int exp_cyc);
        int wr0, m0, f0, cnt, writes, ngaps;
        bit coll;
        wr0 = wr_count;
        m0 = mem_cnt;
        f0 = fetch_t.size();
        exp_q.delete();
        coll = 1'b0;
        writes = 0;
        if (op == 0) begin
            for (int i = 0; i < 1024; i++) exp_fb[i] = 8'h00;
            writes = 1024;
        end else if (op == 1 || op == 2) begin
            model_sprite(op, src, h, x, y, coll, writes);
        end
        @(negedge clk);
        blit_op = 3'(op);
        blit_src = 12'(src);
        blit_srcHeight = 4'(h);
        blit_destX = 7'(x);
        blit_destY = 6'(y);
        blit_enable = 1'b1;
        in_clear = (op == 0);
        clear_base = wr_count;
        @(negedge clk);
        if (!toggle) blit_enable = 1'b0;
        cnt = 0;
        while (!blit_done && cnt < 5000) begin
            cnt++;
            if (toggle && cnt < 1000) blit_enable = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        blit_enable = 1'b0;
        chk({tag, "_done"}, blit_done, 1'b1);
        if (exp_cyc >= 0) chk({tag, "_busy_cycles"}, cnt, exp_cyc);
        repeat (3) @(negedge clk);
        in_clear = 1'b0;
        chk({tag, "_done_hold"}, blit_done, 1'b1);
        chk({tag, "_coll"}, blit_collision, coll);
        chk({tag, "_writes"}, wr_count - wr0, writes);
        chk({tag, "_fb"}, fb_diff(), 0);
        if (op == 0) chk({tag, "_clear_order"}, seq_err, 0);
        if (op == 0 || op > 2 || (op == 1 && h == 0)) chk({tag, "_mem"}, mem_cnt - m0, 0);
        ngaps = (fetch_t.size() - f0 > 0) ? fetch_t.size() - f0 - 1 : 0;
        chk({tag, "_rows"}, ngaps, exp_q.size());
        for (int i = 0; i < ngaps && exp_q.size() > 0; i++)
            chk({tag, "_row_latency"}, fetch_t[f0 + i + 1] - fetch_t[f0 + i], exp_q.pop_front());
    endtask

    initial begin
        int wr_snap;
        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'hF0;
        for (int i = 0; i < 32; i++) ram[12'h100 + i] = 8'hFF;

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_done", blit_done, 1'b1);
        chk("rst_coll", blit_collision, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_fb_en", fb_en, 1'b0);
        chk("rst_fb_wr", fb_wr, 1'b0);
        chk("rst_fb_addr", fb_addr, 10'h000);
        chk("rst_mem_addr", mem_addr, 12'h000);
        chk("rst_fb_in", fb_in, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-screen clear over 0xFF with enable chatter while busy.
        fill_fb(8'hFF);
        run_op("clear", 0, 0, 0, 0, 0, 1'b1, 1025);

        run_op("spr_first", 1, 0, 1, 4, 0, 1'b0, -1);
        chk("spr_first_a0", fb[0], 8'h0F);
        chk("spr_first_a1", fb[1], 8'h00);
        run_op("spr_again", 1, 0, 1, 4, 0, 1'b0, -1);
        chk("spr_again_coll", blit_collision, 1'b1);
        repeat (10) @(negedge clk);
        chk("coll_hold", blit_collision, 1'b1);

        run_op("bad_op", 5, 0, 3, 0, 0, 1'b0, 1);
        run_op("h_zero", 1, 0, 0, 0, 0, 1'b0, 1);

        run_op("s16_corner", 2, 12'h100, 0, 120, 60, 1'b0, -1);
        chk("s16_corner_c15", fb[60 * 16 + 15], 8'hFF);
`ifdef BLIT_WRAP_EN
        chk("s16_corner_wrap", fb[0], 8'hFF);
`else
        chk("s16_corner_clip", fb[0], 8'h00);
`endif

        for (int n = 0; n < 12; n++) begin
            int op, x, y;
            op = $urandom_range(1, 2);
            x = (n % 3 == 0) ? $urandom_range(104, 127) : $urandom_range(0, 127);
            y = (n % 4 == 0) ? $urandom_range(50, 63) : $urandom_range(0, 63);
            run_op("rand", op, $urandom_range(0, 4095), $urandom_range(0, 15), x, y, 1'b0, -1);
        end

        // Abort a tall sprite in its first FB_WR with the start request still held.
        @(negedge clk);
        blit_op = 3'd1;
        blit_src = 12'h200;
        blit_srcHeight = 4'hF;
        blit_destX = 7'd10;
        blit_destY = 6'd5;
        blit_enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_pre_wr", fb_wr, 1'b1);
        #2 rst_n = 1'b0;
        wr_snap = wr_count;
        #1;
        chk("abort_fb_wr", fb_wr, 1'b0);
        chk("abort_done", blit_done, 1'b1);
        chk("abort_coll", blit_collision, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("abort_no_restart", blit_done, 1'b1);
        chk("abort_no_writes", wr_count - wr_snap, 0);
        chk("abort_fb", fb_diff(), 0);
        blit_enable = 1'b0;
        repeat (2) @(negedge clk);
        run_op("recover", 7, 0, 0, 0, 0, 1'b0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/blitter.md
BLITTER -- requirements
Module: blitter

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk  in  1  system clock; rst_n  in  1  asynchronous active-low reset.
REQ-002 blit_op  in  3  operation code: 0 = CLEAR, 1 = SPRITE (8 wide), 2 = SPRITE_16 (16x16); other codes are no-ops.
REQ-003 blit_src  in  12  sprite source byte address in program RAM.
REQ-004 blit_srcHeight  in  4  SPRITE row count, 1..15.
REQ-005 blit_destX  in  7 and blit_destY  in  6  destination pixel coordinates, 128x64 plane.
REQ-006 blit_enable  in  1  start request, level; the rising edge is sampled.
REQ-007 blit_done  out  1  high while idle; blit_collision  out  1  result of the last sprite operation.
REQ-008 mem_en  out  1, mem_addr  out  12, mem_out  in  8  synchronous program-RAM read port; data is valid 2 cycles after the address is driven.
REQ-009 fb_en  out  1, fb_wr  out  1, fb_addr  out  10, fb_in  out  8, fb_out  in  8  framebuffer port; fb_addr = {y[5:0], x[6:3]}; pixel x is bit 7-x[2:0]; read latency is 2 cycles.

Function
REQ-010 The block SHALL accept a start only in IDLE, on the clk edge where blit_enable is 1 and was 0 on the previous edge. On that edge it SHALL latch all blit_* inputs and clear blit_done.
REQ-011 A blit_enable edge seen outside IDLE SHALL be ignored.
REQ-012 States: IDLE, CLEAR, FETCH, FETCH_WAIT, FB_RD, FB_WAIT, FB_WR, NEXT_ROW, FINISH.
REQ-013 CLEAR SHALL write 0x00 to fb_addr 0..1023, one write per cycle, in ascending order. It SHALL then enter FINISH, with blit_collision = 0.
REQ-014 SPRITE SHALL process rows r = 0..H-1, where H = blit_srcHeight. Row r reads byte src+r. SPRITE with H = 0 SHALL go straight to FINISH with collision 0.
REQ-015 SPRITE_16 SHALL process 16 rows. Row r reads bytes src+2r (left half) and src+2r+1 (right half).
REQ-016 Source addresses SHALL wrap modulo 4096.
REQ-017 Each row pattern SHALL be right-shifted by destX[2:0] into a 16-bit span (8-wide sprites) or a 24-bit span (16-wide sprites), zero-filled.
REQ-018 Each span byte SHALL be written to its target byte with a read-modify-write sequence: FB_RD, FB_WAIT, FB_WR, in that order. The written value SHALL be old XOR pattern. All span bytes SHALL be written, including zero-pattern bytes.
REQ-019 blit_collision SHALL be set if (old AND pattern) != 0 for any byte of the operation. It SHALL be cleared at the start of each operation.
REQ-020 Per-row latency SHALL be 2 cycles per source byte plus 3 cycles per span byte: 8 cycles for SPRITE, 13 cycles for SPRITE_16.
REQ-021 FINISH SHALL drive mem_en, fb_en and fb_wr low and set blit_done. blit_collision SHALL be valid on the same edge that blit_done rises.
REQ-022 blit_collision SHALL hold its value until the next accepted start.
REQ-023 mem_en SHALL be high only in FETCH and FETCH_WAIT.
REQ-024 fb_wr SHALL be high only in CLEAR and FB_WR.
REQ-025 Unknown blit_op values SHALL go from start to FINISH in 1 cycle with no memory access.

Reset
REQ-026 While rst_n is low: state = IDLE, blit_done = 1, blit_collision = 0, and mem_en, fb_en, fb_wr = 0. fb_addr, mem_addr and fb_in SHALL be 0.
REQ-027 Asserting rst_n mid-operation SHALL abort the operation immediately. No further framebuffer write SHALL occur after reset assertion.
REQ-028 After rst_n deasserts, a blit_enable already held high SHALL NOT start an operation until it has been seen low.

Configuration
REQ-029 Macro BLIT_WRAP_EN. When defined, span bytes with byte column > 15 SHALL wrap modulo 16, and rows with y > 63 SHALL wrap modulo 64.
REQ-030 When BLIT_WRAP_EN is undefined, such bytes and rows SHALL be clipped. Clipped bytes get no read, no write and no collision contribution, and take 0 cycles.

Verification
REQ-031 CLEAR on a framebuffer full of 0xFF -> 1024 writes of 0x00; blit_done low for 1025 cycles; collision 0.
REQ-032 SPRITE, src=0x000 holding 0xF0, H=1, X=4, Y=0, empty framebuffer -> addr 0 = 0x0F, addr 1 = 0x00; collision 0.
REQ-033 The same sprite drawn twice -> framebuffer restored to all zeros; second collision = 1.
REQ-034 SPRITE_16 at X=120, Y=60 with all bytes 0xFF -> with BLIT_WRAP_EN: rows 60..63 and rows 0..11 written, columns 15 and 0 touched. Without BLIT_WRAP_EN: only the 4 row-60..63 bytes at column 15 change.
REQ-035 rst_n pulsed low at cycle 5 of a SPRITE H=15 -> fb_wr drops immediately; blit_done = 1, collision = 0. A held-high blit_enable does not restart the operation.
REQ-036 blit_enable toggled during a busy CLEAR -> ignored; exactly 1024 writes; done rises once.
